// File: rtl/ysyx_23060111_wb_arb.sv
// Writeback arbiter and load scoreboard for the NPC register file.
// Define YSYX_23060111_WBARB_RR_EN for round-robin; default is LSU-first.
module ysyx_23060111_wb_arb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  idle
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            wr_lsu;
  logic            exu_elig;
  logic            both;
  logic            grant_exu;
  logic            grant_lsu;

  // WAW guard: an ALU write must not land before an older load to the same rd
  assign exu_elig = !(busy[exu_rd] && exu_rd != '0);
  assign both     = exu_valid && exu_elig && lsu_valid;

`ifdef YSYX_23060111_WBARB_RR_EN
  logic ptr;

  assign grant_lsu = lsu_valid && (!both || ptr);
  assign grant_exu = exu_valid && exu_elig && (!both || !ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (both) begin
      ptr <= grant_exu;
    end
  end
`else
  assign grant_lsu = lsu_valid;
  assign grant_exu = exu_valid && exu_elig && !lsu_valid;
`endif

  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;
  assign iss_ready = !(busy[iss_rd] && iss_rd != '0);
  assign busy1     = busy[raddr1];
  assign busy2     = busy[raddr2];
  assign idle      = (busy == '0) && !rf_wen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wr_lsu   <= 1'b0;
    end else begin
      rf_wen <= 1'b0;
      wr_lsu <= 1'b0;
      if (grant_lsu) begin
        rf_wen   <= lsu_rd != '0;
        rf_waddr <= lsu_rd;
        rf_wdata <= lsu_data;
        wr_lsu   <= 1'b1;
      end else if (grant_exu) begin
        rf_wen   <= exu_rd != '0;
        rf_waddr <= exu_rd;
        rf_wdata <= exu_data;
      end
    end
  end

  // Set is applied after clear so a same-cycle issue keeps the bit
  always_comb begin
    busy_nxt = busy;
    if (rf_wen && wr_lsu) begin
      busy_nxt[rf_waddr] = 1'b0;
    end
    if (iss_valid && iss_ready && iss_rd != '0) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_23060111_wb_arb.sv
// Directed bench for ysyx_23060111_wb_arb.
// Inputs change on the falling edge; outputs are sampled there or 1ns later.
module tb_ysyx_23060111_wb_arb;

  logic        clk;
  logic        rst_n;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        busy1;
  logic        busy2;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        idle;

  int checks;
  int failures;

  ysyx_23060111_wb_arb dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_rd(exu_rd),
    .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd),
    .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_ready(iss_ready),
    .raddr1(raddr1), .raddr2(raddr2),
    .busy1(busy1), .busy2(busy2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs;
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    iss_valid = 0; iss_rd = 0;
    raddr1 = 0; raddr2 = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_wr: wen=%b addr=%0d data=%h want 0/0/0", rf_wen, rf_waddr, rf_wdata);
    end
    checks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL reset_sb: busy1=%b busy2=%b idle=%b want 0/0/1", busy1, busy2, idle);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (idle !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle: idle=%b want 1", idle);
    end
  endtask

  task automatic test_load_wb;
    @(negedge clk);
    iss_valid = 1; iss_rd = 5; raddr1 = 5;
    #1;
    checks++;
    if (iss_ready !== 1'b1 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL lwb_issue: iss_ready=%b busy1=%b want 1/0", iss_ready, busy1);
    end
    @(negedge clk);
    iss_valid = 0;
    checks++;
    if (busy1 !== 1'b1 || idle !== 1'b0) begin
      failures++;
      $display("FAIL lwb_busy: busy1=%b idle=%b want 1/0", busy1, idle);
    end
    lsu_valid = 1; lsu_rd = 5; lsu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin
      failures++;
      $display("FAIL lwb_hs: lsu_ready=%b exu_ready=%b want 1/0", lsu_ready, exu_ready);
    end
    @(negedge clk);
    lsu_valid = 0;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL lwb_write: wen=%b addr=%0d data=%h busy1=%b want 1/5/deadbeef/1", rf_wen, rf_waddr, rf_wdata, busy1);
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || rf_wen !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL lwb_clear: busy1=%b wen=%b idle=%b want 0/0/1", busy1, rf_wen, idle);
    end
  endtask

  task automatic test_x0;
    @(negedge clk);
    exu_valid = 1; exu_rd = 0; exu_data = 32'h1234;
    #1;
    checks++;
    if (exu_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_ready: exu_ready=%b want 1", exu_ready);
    end
    @(negedge clk);
    exu_valid = 0;
    checks++;
    if (rf_wen !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL x0_nowrite: wen=%b idle=%b want 0/1", rf_wen, idle);
    end
  endtask

  task automatic test_waw;
    @(negedge clk);
    iss_valid = 1; iss_rd = 7;
    @(negedge clk);
    iss_valid = 0;
    exu_valid = 1; exu_rd = 7; exu_data = 32'hAAAA0007;
    #1;
    checks++;
    if (exu_ready !== 1'b0) begin
      failures++;
      $display("FAIL waw_stall0: exu_ready=%b want 0", exu_ready);
    end
    @(negedge clk);
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h11110007;
    #1;
    checks++;
    if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin
      failures++;
      $display("FAIL waw_lsu: lsu_ready=%b exu_ready=%b want 1/0", lsu_ready, exu_ready);
    end
    @(negedge clk);
    lsu_valid = 0;
    #1;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11110007 || exu_ready !== 1'b0) begin
      failures++;
      $display("FAIL waw_load: wen=%b addr=%0d data=%h exu_ready=%b want 1/7/11110007/0", rf_wen, rf_waddr, rf_wdata, exu_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exu_ready !== 1'b1) begin
      failures++;
      $display("FAIL waw_release: exu_ready=%b want 1", exu_ready);
    end
    @(negedge clk);
    exu_valid = 0;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hAAAA0007) begin
      failures++;
      $display("FAIL waw_final: wen=%b addr=%0d data=%h want 1/7/aaaa0007", rf_wen, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    checks++;
    if (rf_wen !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL waw_idle: wen=%b idle=%b want 0/1", rf_wen, idle);
    end
  endtask

  task automatic test_arb;
    logic       exp_e;
    logic [4:0] exp_addr;
    exp_addr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== exp_addr) begin
          failures++;
          $display("FAIL arb_write%0d: wen=%b addr=%0d want 1/%0d", i, rf_wen, rf_waddr, exp_addr);
        end
      end
      exu_valid = 1; exu_rd = 5'(10 + i); exu_data = 32'hE0000000 + i;
      lsu_valid = 1; lsu_rd = 5'(20 + i); lsu_data = 32'hD0000000 + i;
`ifdef YSYX_23060111_WBARB_RR_EN
      exp_e = (i % 2) == 0;
`else
      exp_e = 1'b0;
`endif
      exp_addr = exp_e ? 5'(10 + i) : 5'(20 + i);
      #1;
      checks++;
      if (exu_ready !== exp_e || lsu_ready !== !exp_e) begin
        failures++;
        $display("FAIL arb_grant%0d: exu_ready=%b lsu_ready=%b want %b/%b", i, exu_ready, lsu_ready, exp_e, !exp_e);
      end
    end
    @(negedge clk);
    exu_valid = 0; lsu_valid = 0;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== exp_addr) begin
      failures++;
      $display("FAIL arb_write4: wen=%b addr=%0d want 1/%0d", rf_wen, rf_waddr, exp_addr);
    end
  endtask

  task automatic test_set_wins;
    @(negedge clk);
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h33;
    @(negedge clk);
    lsu_valid = 0;
    iss_valid = 1; iss_rd = 3; raddr2 = 3;
    #1;
    checks++;
    if (iss_ready !== 1'b1 || rf_wen !== 1'b1 || rf_waddr !== 5'd3) begin
      failures++;
      $display("FAIL sw_same: iss_ready=%b wen=%b addr=%0d want 1/1/3", iss_ready, rf_wen, rf_waddr);
    end
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b1) begin
      failures++;
      $display("FAIL sw_set: busy2=%b want 1", busy2);
    end
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h44;
    #1;
    checks++;
    if (iss_ready !== 1'b0) begin
      failures++;
      $display("FAIL sw_stall_n: iss_ready=%b want 0", iss_ready);
    end
    @(negedge clk);
    lsu_valid = 0;
    #1;
    checks++;
    if (iss_ready !== 1'b0) begin
      failures++;
      $display("FAIL sw_stall_n1: iss_ready=%b want 0", iss_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (iss_ready !== 1'b1 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL sw_accept_n2: iss_ready=%b busy2=%b want 1/0", iss_ready, busy2);
    end
    @(negedge clk);
    iss_valid = 0;
    checks++;
    if (busy2 !== 1'b1) begin
      failures++;
      $display("FAIL sw_reissue: busy2=%b want 1", busy2);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    iss_valid = 1; iss_rd = 9; raddr1 = 9;
    @(negedge clk);
    iss_valid = 0;
    exu_valid = 1; exu_rd = 12; exu_data = 32'hC0DE;
    @(negedge clk);
    exu_valid = 0;
    checks++;
    if (rf_wen !== 1'b1 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL ar_pre: wen=%b busy1=%b want 1/1", rf_wen, busy1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      failures++;
      $display("FAIL ar_wr: wen=%b addr=%0d data=%h want 0/0/0", rf_wen, rf_waddr, rf_wdata);
    end
    checks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL ar_sb: busy1=%b busy2=%b idle=%b want 0/0/1", busy1, busy2, idle);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rf_wen !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL ar_after: wen=%b idle=%b want 0/1", rf_wen, idle);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear_inputs();
    test_reset();
    test_load_wb();
    test_x0();
    test_waw();
    test_arb();
    test_set_wins();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
